// File: rtl/rr_preset_regbank_pkg.sv
// Shared types and helpers for the round-robin register bank: FSM state
// encoding, a constant clog2 and a grant one-hot builder.
package rr_preset_regbank_pkg;

  localparam int MAX_NREQ = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Bits at or above nreq are never set, so callers may truncate to nreq bits.
  function automatic logic [MAX_NREQ-1:0] onehot(input int idx, input int nreq);
    logic [MAX_NREQ-1:0] v;
    v = {MAX_NREQ{1'b0}};
    for (int i = 0; i < MAX_NREQ; i++) begin
      if ((i == idx) && (i < nreq)) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_preset_regbank_if.sv
// Write-port / read-port bundle between the requesters (master) and the
// shared register bank (slave).
interface rr_preset_regbank_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 3
);
  logic                 clr;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdata;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic [AW-1:0]        rd_addr;
  logic [DW-1:0]        rd_data;
  logic                 wr_err;

  modport master (
    output clr, req, addr, wdata, rd_addr,
    input  gnt, busy, rd_data, wr_err
  );

  modport slave (
    input  clr, req, addr, wdata, rd_addr,
    output gnt, busy, rd_data, wr_err
  );
endinterface

// File: rtl/rr_preset_regbank_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward
// from ptr_i with wrap-around.
module rr_arbiter_core
  import rr_preset_regbank_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   winner_o,
  output logic            valid_o
);

  logic [2*NREQ-1:0] dbl_s;
  logic [NREQ-1:0]   rot_s;
  int                sum_s;

  // Rotate so bit k of rot_s is requester (ptr+k) mod NREQ; ptr_i < NREQ always.
  always_comb begin
    dbl_s = {req_i, req_i} >> ptr_i;
    rot_s = dbl_s[NREQ-1:0];
  end

  // Lowest rotated bit wins; translate back to an absolute requester index.
  always_comb begin
    winner_o = {PW{1'b0}};
    valid_o  = 1'b0;
    sum_s    = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid_o && rot_s[k]) begin
        valid_o = 1'b1;
        sum_s   = int'(ptr_i) + k;
        if (sum_s >= NREQ) begin
          sum_s = sum_s - NREQ;
        end else begin
          sum_s = sum_s;
        end
        winner_o = PW'(sum_s);
      end else begin
        winner_o = winner_o;
      end
    end
  end

endmodule

// File: rtl/rr_preset_regbank.sv
// Register bank of NREG async-preset flops with a single write port shared by
// NREQ requesters through a round-robin arbiter (IDLE grant, WRITE commit).
module rr_preset_regbank
  import rr_preset_regbank_pkg::*;
#(
  parameter int              NREQ     = 4,
  parameter int              NREG     = 6,
  parameter int              DW       = 8,
  parameter int              AW       = clog2(NREG),
  parameter logic [DW-1:0]   REG_INIT = {DW{1'b1}}
) (
  input logic               CLK,
  input logic               PRESET,
  rr_preset_regbank_if.slave bus
);

  localparam int PW = clog2(NREQ);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   lat_addr_q, lat_addr_d;
  logic [DW-1:0]   lat_data_q, lat_data_d;
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic            wr_err_q, wr_err_d;

  logic [PW-1:0]   winner_s;
  logic            valid_s;
  logic            in_range_s;
  logic [DW-1:0]   rd_data_s;

  rr_arbiter_core #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .winner_o (winner_s),
    .valid_o  (valid_s)
  );

  assign in_range_s = (int'(lat_addr_q) < NREG);

  // Next-state: grant/latch in IDLE, commit in WRITE; clr overrides any commit.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = {NREQ{1'b0}};
    busy_d     = 1'b0;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    regs_d     = regs_q;
    wr_err_d   = wr_err_q;
    case (state_q)
      IDLE: begin
        if (valid_s) begin
          gnt_d      = NREQ'(onehot(int'(winner_s), NREQ));
          lat_addr_d = bus.addr[winner_s*AW +: AW];
          lat_data_d = bus.wdata[winner_s*DW +: DW];
          busy_d     = 1'b1;
          state_d    = WRITE;
          if (int'(winner_s) == NREQ - 1) begin
            ptr_d = {PW{1'b0}};
          end else begin
            ptr_d = winner_s + PW'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (in_range_s) begin
          for (int i = 0; i < NREG; i++) begin
            if (lat_addr_q == AW'(i)) begin
              regs_d[i] = lat_data_q;
            end else begin
              regs_d[i] = regs_q[i];
            end
          end
        end else begin
          wr_err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.clr) begin
      for (int i = 0; i < NREG; i++) begin
        regs_d[i] = {DW{1'b0}};
      end
      wr_err_d = 1'b0;
    end else begin
      wr_err_d = wr_err_d;
    end
  end

  // State and register bank, asynchronously preset.
  always_ff @(posedge CLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      ptr_q      <= {PW{1'b0}};
      gnt_q      <= {NREQ{1'b0}};
      busy_q     <= 1'b0;
      lat_addr_q <= {AW{1'b0}};
      lat_data_q <= {DW{1'b0}};
      wr_err_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= REG_INIT;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      wr_err_q   <= wr_err_d;
      regs_q     <= regs_d;
    end
  end

  // Read port has no write bypass; unmapped addresses return zero.
  always_comb begin
    rd_data_s = {DW{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      if (bus.rd_addr == AW'(i)) begin
        rd_data_s = regs_q[i];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  assign bus.rd_data = rd_data_s;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.wr_err  = wr_err_q;

endmodule

// File: doc/rr_preset_regbank.md
Name: rr_preset_regbank

Overview:
- Shared register bank of NREG enable-gated registers. NREQ requesters share a single write port through a round-robin arbiter.
- Registers behave like positive-edge, async-preset, clock-enabled flops. PRESET forces every register to REG_INIT; a synchronous clear forces them to zero.
- Used as the configuration/status register file behind multi-master control logic in Gowin designs.

Parameters:
- NREQ, 4, number of write requesters (2..8)
- NREG, 6, number of registers in the bank (1..2**AW)
- DW, 8, register data width
- AW, 3, address width, must satisfy 2**AW >= NREG
- REG_INIT, {DW{1'b1}}, value loaded into every register on PRESET

Ports:
- CLK  in  1  clock, all state updates on rising edge
- PRESET  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of all registers and wr_err
- req  in  NREQ  per-requester write request, level
- addr  in  NREQ*AW  per-requester write address, requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  per-requester write data, requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot grant pulse, registered
- busy  out  1  high while in WRITE state
- rd_addr  in  AW  read address
- rd_data  out  DW  combinational read of regs[rd_addr]
- wr_err  out  1  sticky out-of-range write flag

Behaviour:
- Reset: PRESET is asynchronous, active-high; clock is CLK. While PRESET is high:
  - all regs = REG_INIT
  - gnt = 0, busy = 0, wr_err = 0
  - state = IDLE, rr pointer ptr = 0
- Release of PRESET takes effect at the next CLK edge. No synchronizer is included.
- FSM has two states, IDLE and WRITE.
- IDLE with any req high, at a CLK edge:
  - winner w = first i with req[i]=1, scanning ptr, ptr+1, ... mod NREQ
  - gnt <= onehot(w)
  - lat_addr <= addr[w], lat_data <= wdata[w]
  - ptr <= (w+1) mod NREQ
  - state <= WRITE, busy <= 1
- IDLE with no req: nothing changes and gnt stays 0.
- WRITE, at the next CLK edge:
  - if lat_addr < NREG, regs[lat_addr] <= lat_data; otherwise no register changes and wr_err <= 1
  - gnt <= 0, busy <= 0, state <= IDLE
- Throughput: at most one write per 2 cycles.
  - Latency from the req sample edge to the register update is 2 edges.
  - gnt is high for exactly 1 cycle, the cycle where busy=1.
- Requester protocol:
  - a request is accepted when its gnt bit is seen high
  - the requester must deassert req, or present new data, before the following IDLE sample; a still-high req is treated as a new request
  - addr/wdata only need to be stable at the sample edge
- clr at a CLK edge:
  - all regs <= 0 and wr_err <= 0
  - clr takes precedence over a WRITE-state write in the same cycle; that write is dropped, but gnt/busy/state still advance normally
  - arbitration in IDLE is unaffected by clr
- PRESET asserted mid-WRITE: the pending write is lost; all state returns to its reset values immediately.
- rd_data:
  - regs[rd_addr] if rd_addr < NREG, else 0
  - a same-cycle write is visible only after the write edge, so there is no bypass
- Fairness: a requester held high continuously is granted within NREQ grants.

Decomposition:
- Shared package holds the FSM state typedef (IDLE, WRITE) and a function onehot(idx, NREQ).
- A shared function clog2 computes the default AW.
- One sub-module, rr_arbiter_core: inputs req and ptr; outputs winner index and a valid flag; purely combinational.
- The top level holds the FSM, the latch registers, the register array and wr_err.

Test Plan:
- PRESET pulse mid-run: all regs read 8'hFF, gnt=0, busy=0, wr_err=0 during and immediately after PRESET, with no CLK edge needed.
- Single write, req[2]=1, addr=3, wdata=8'h5A held 1 cycle: gnt=4'b0100 and busy=1 at edge+1; rd_data@3=8'h5A after edge+2; other regs stay 8'hFF.
- All four req held high from reset: grant order is 0,1,2,3,0; gnt is one-hot each grant; one grant every 2 cycles.
- Out-of-range write (addr=6 with NREG=6): no register changes and wr_err=1 after the write edge. A following clr gives wr_err=0 and all regs=0.
- clr asserted on the WRITE-state edge of a write of 8'hA5 to reg 1: reg1=0 afterwards, gnt still pulses, state returns to IDLE.
- PRESET asserted while busy=1 (write of 8'h00 to reg 0 pending): reg0 stays 8'hFF, busy drops immediately, and the first grant after release goes to requester 0 (ptr=0).
